// File: rtl/match_window_counter_pkg.sv
// -----------------------------------------------------------------------------
// match_window_counter_pkg
//
// Purpose:
//   Shared definitions for the match window counter slice: the FSM state
//   encoding, the default window length and count width, and a helper that
//   sizes the window down-counter.
//
// Contents:
//   DEFAULT_WIN_LEN  default window length in clock cycles
//   DEFAULT_CNT_W    default width of the match count and alarm threshold
//   state_t          FSM states, IDLE = 0 and RUN = 1
//   win_cnt_width()  bit width needed to hold 0 .. win_len-1
// -----------------------------------------------------------------------------
package match_window_counter_pkg;

  localparam int DEFAULT_WIN_LEN = 16;
  localparam int DEFAULT_CNT_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The window counter only ever holds WIN_LEN-1 down to 0. A one-bit floor
  // keeps the declaration legal if someone ever instantiates a degenerate
  // window length.
  function automatic int win_cnt_width(input int win_len);
    if (win_len < 2) begin
      return 1;
    end
    return $clog2(win_len);
  endfunction

endpackage

// File: rtl/match_sat_counter.sv
// -----------------------------------------------------------------------------
// match_sat_counter
//
// Purpose:
//   CNT_W-bit up-counter that sticks at its all-ones value. It also keeps a
//   flag recording that at least one increment arrived while the counter was
//   already at its maximum, which means the count no longer reflects every
//   event.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   clear      in   synchronous clear of count and flag; wins over inc
//   inc        in   count one event this cycle
//   count      out  registered count
//   sat        out  registered saturation flag
//   count_inc  out  count as it would be with this cycle's inc applied
//   sat_inc    out  flag as it would be with this cycle's inc applied
//
// The *_inc outputs let the owner capture a final value that includes the
// event of the current cycle, even in a cycle where it also clears.
// -----------------------------------------------------------------------------
module match_sat_counter
  import match_window_counter_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic [CNT_W-1:0] count_inc,
  output logic             sat_inc
);

  localparam logic [CNT_W-1:0] COUNT_MAX = '1;

  logic at_max;

  assign at_max = (count == COUNT_MAX);

  // An increment at the maximum is lost; that lost event is what marks the
  // count as saturated. Reaching the maximum exactly is still a true count.
  always_comb begin
    count_inc = count;
    sat_inc   = sat;
    if (inc) begin
      if (at_max) begin
        sat_inc = 1'b1;
      end else begin
        count_inc = count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= count_inc;
      sat   <= sat_inc;
    end
  end

endmodule

// File: rtl/match_window_counter.sv
// -----------------------------------------------------------------------------
// match_window_counter
//
// Purpose:
//   Counts single-cycle match pulses over back-to-back windows of WIN_LEN
//   cycles while enabled. At the end of each window the count is offered on
//   a valid/ready result port. A result that cannot be stored because the
//   previous one is still unconsumed is dropped and flagged by the sticky
//   ovr output. A live alarm compares the count of the current window with
//   a threshold.
//
// Parameters:
//   WIN_LEN    window length in clock cycles (>= 2)
//   CNT_W      width of the match count and of the threshold
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   R          in   asynchronous reset, active low, clears all state
//   en         in   1 runs windows back to back, 0 aborts or idles
//   match      in   one-cycle detection pulse from the upstream detector
//   thr        in   alarm threshold, 0 disables the alarm
//   cnt_data   out  match count of the last completed window
//   cnt_valid  out  cnt_data holds a result not yet consumed
//   cnt_ready  in   consumer takes the result when cnt_valid && cnt_ready
//   sat        out  the result in cnt_data is saturated
//   alarm      out  live window count >= thr (combinational)
//   ovr        out  sticky, a completed result was dropped
// -----------------------------------------------------------------------------
module match_window_counter
  import match_window_counter_pkg::*;
#(
  parameter int WIN_LEN = DEFAULT_WIN_LEN,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             R,
  input  logic             en,
  input  logic             match,
  input  logic [CNT_W-1:0] thr,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             sat,
  output logic             alarm,
  output logic             ovr
);

  localparam int               WIN_W    = win_cnt_width(WIN_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

  state_t           state;
  state_t           state_next;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_cnt_next;

  logic             last_cycle;
  logic             count_clear;
  logic             count_inc;

  logic [CNT_W-1:0] live_count;
  logic             live_sat;
  logic [CNT_W-1:0] final_count;
  logic             final_sat;

  logic             result_free;
  logic             result_load;
  logic             result_drop;

  // The window counter walks WIN_LAST down to 0 and the cycle where it
  // reads 0 is the final cycle of the window. The live count is cleared
  // on every edge that starts a window (from IDLE, or straight after a
  // final cycle) and on every edge that leaves or stays in IDLE, so a
  // fresh window always begins at zero. Dropping en aborts immediately,
  // including on the final cycle, so no result is produced.
  always_comb begin
    state_next   = state;
    win_cnt_next = win_cnt;
    last_cycle   = 1'b0;
    count_clear  = 1'b0;
    count_inc    = 1'b0;
    case (state)
      IDLE: begin
        count_clear  = 1'b1;
        win_cnt_next = '0;
        if (en) begin
          state_next   = RUN;
          win_cnt_next = WIN_LAST;
        end
      end
      RUN: begin
        if (!en) begin
          state_next   = IDLE;
          count_clear  = 1'b1;
          win_cnt_next = '0;
        end else begin
          count_inc = match;
          if (win_cnt == '0) begin
            last_cycle   = 1'b1;
            count_clear  = 1'b1;
            win_cnt_next = WIN_LAST;
          end else begin
            win_cnt_next = win_cnt - 1'b1;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        count_clear  = 1'b1;
        win_cnt_next = '0;
      end
    endcase
  end

  // FSM state and window position.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state   <= IDLE;
      win_cnt <= '0;
    end else begin
      state   <= state_next;
      win_cnt <= win_cnt_next;
    end
  end

  // Live count of the current window. count_inc/sat_inc from the counter
  // already include a match in the final cycle, which is exactly the value
  // the result register captures.
  match_sat_counter #(
    .CNT_W (CNT_W)
  ) u_count (
    .clk       (clk),
    .rst_n     (R),
    .clear     (count_clear),
    .inc       (count_inc),
    .count     (live_count),
    .sat       (live_sat),
    .count_inc (final_count),
    .sat_inc   (final_sat)
  );

  // The result slot is free when empty or when it is being consumed on the
  // same edge, so a window ending under a handshake reloads cnt_valid
  // without a bubble.
  assign result_free = !cnt_valid || cnt_ready;
  assign result_load = last_cycle && result_free;
  assign result_drop = last_cycle && !result_free;

  // Result register and handshake. cnt_data and sat only change on a load,
  // which keeps them stable for as long as an offered result waits.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      cnt_data  <= '0;
      sat       <= 1'b0;
      cnt_valid <= 1'b0;
    end else if (result_load) begin
      cnt_data  <= final_count;
      sat       <= final_sat;
      cnt_valid <= 1'b1;
    end else if (cnt_valid && cnt_ready) begin
      cnt_valid <= 1'b0;
    end
  end

  // Overrun flag; once set it stays set until reset.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      ovr <= 1'b0;
    end else if (result_drop) begin
      ovr <= 1'b1;
    end
  end

  // The alarm looks at the registered live count, so a match in the current
  // cycle shows up in the alarm one cycle later.
  assign alarm = (state == RUN) && (thr != '0) && (live_count >= thr);

  // live_sat only matters at the final cycle, via final_sat.
  logic unused_live_sat;
  assign unused_live_sat = live_sat;

endmodule

// File: tb/tb_match_window_counter.sv
// -----------------------------------------------------------------------------
// tb_match_window_counter
//
// Drives match_window_counter (WIN_LEN=16, CNT_W=4) one cycle at a time and
// compares every output against a reference model, before each clock edge.
// The model tracks window position and the plain number of matches seen;
// the result is that number clipped to 15, and it counts as saturated when
// more than 15 matches arrived in the window.
// -----------------------------------------------------------------------------
module tb_match_window_counter;

  localparam int WIN_LEN = 16;
  localparam int CNT_W   = 4;
  localparam int MAXC    = 15;

  logic             clk = 1'b0;
  logic             R;
  logic             en;
  logic             match;
  logic [CNT_W-1:0] thr;
  logic [CNT_W-1:0] cnt_data;
  logic             cnt_valid;
  logic             cnt_ready;
  logic             sat;
  logic             alarm;
  logic             ovr;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit m_run;
  int m_pos;
  int m_matches;
  bit m_hv;
  int m_hd;
  bit m_hs;
  bit m_ovr;

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  thr;
    int          exp_data;
    logic        exp_sat;
  } win_vec_t;

  win_vec_t vecs[7];

  always #5 clk = ~clk;

  match_window_counter #(
    .WIN_LEN (WIN_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .R         (R),
    .en        (en),
    .match     (match),
    .thr       (thr),
    .cnt_data  (cnt_data),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .sat       (sat),
    .alarm     (alarm),
    .ovr       (ovr)
  );

  task automatic check_value(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_run     = 0;
    m_pos     = 0;
    m_matches = 0;
    m_hv      = 0;
    m_hd      = 0;
    m_hs      = 0;
    m_ovr     = 0;
  endtask

  // One rising edge of the reference behaviour, using the inputs driven
  // during the cycle that just ended.
  task automatic model_edge();
    bit accept;
    bit loaded;
    accept = m_hv && cnt_ready;
    loaded = 0;
    if (m_run && en) begin
      if (match) m_matches++;
      if (m_pos == WIN_LEN - 1) begin
        if (!m_hv || cnt_ready) begin
          m_hv   = 1;
          m_hd   = (m_matches > MAXC) ? MAXC : m_matches;
          m_hs   = (m_matches > MAXC);
          loaded = 1;
        end else begin
          m_ovr = 1;
        end
        m_pos     = 0;
        m_matches = 0;
      end else begin
        m_pos++;
      end
    end else if (m_run) begin
      m_run     = 0;
      m_pos     = 0;
      m_matches = 0;
    end else if (en) begin
      m_run     = 1;
      m_pos     = 0;
      m_matches = 0;
    end
    if (accept && !loaded) m_hv = 0;
  endtask

  task automatic check_output();
    int clipped;
    int exp_alarm;
    clipped   = (m_matches > MAXC) ? MAXC : m_matches;
    exp_alarm = (m_run && thr != 0 && clipped >= int'(thr)) ? 1 : 0;
    check_value("cnt_valid", int'(cnt_valid), int'(m_hv));
    check_value("cnt_data",  int'(cnt_data),  m_hd);
    check_value("sat",       int'(sat),       int'(m_hs));
    check_value("ovr",       int'(ovr),       int'(m_ovr));
    check_value("alarm",     int'(alarm),     exp_alarm);
  endtask

  // Drive one cycle: set inputs, check outputs mid-cycle, take the edge,
  // advance the model, and return 1 time unit after the edge.
  task automatic apply_stimulus(input logic r_v, input logic en_v, input logic match_v,
                                input logic [3:0] thr_v, input logic ready_v);
    R         = r_v;
    en        = en_v;
    match     = match_v;
    thr       = thr_v;
    cnt_ready = ready_v;
    #2;
    if (!R) model_reset();
    check_output();
    @(posedge clk);
    if (R) model_edge();
    #1;
  endtask

  // Runs ncycles enabled cycles; bit c of mask/rdy drives match/cnt_ready
  // on step c.
  task automatic run_window(input logic [15:0] mask, input logic [3:0] t,
                            input logic [15:0] rdy, input int ncycles);
    for (int c = 0; c < ncycles; c++) begin
      apply_stimulus(1'b1, 1'b1, mask[c], t, rdy[c]);
    end
  endtask

  initial begin
    int dens;
    logic r_v, en_v, m_v, rd_v;
    logic [3:0] t_v;

    model_reset();
    vecs[0] = '{16'h8021, 4'd0,  3,  1'b0};
    vecs[1] = '{16'hFFFF, 4'd10, 15, 1'b1};
    vecs[2] = '{16'h7FFF, 4'd15, 15, 1'b0};
    vecs[3] = '{16'h0000, 4'd1,  0,  1'b0};
    vecs[4] = '{16'h8000, 4'd1,  1,  1'b0};
    vecs[5] = '{16'h0001, 4'd2,  1,  1'b0};
    vecs[6] = '{16'hAAAA, 4'd8,  8,  1'b0};

    // Reset, then matches in IDLE and in the entering cycle are ignored.
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    check_value("reset_cnt_valid", int'(cnt_valid), 0);
    check_value("reset_ovr", int'(ovr), 0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 4'd5, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b1, 4'd5, 1'b1);

    // Back-to-back windows from the table, consumer always ready.
    for (int i = 0; i < 7; i++) begin
      run_window(vecs[i].mask, vecs[i].thr, 16'hFFFF, WIN_LEN);
      check_value($sformatf("vec%0d_valid", i), int'(cnt_valid), 1);
      check_value($sformatf("vec%0d_data", i), int'(cnt_data), vecs[i].exp_data);
      check_value($sformatf("vec%0d_sat", i), int'(sat), int'(vecs[i].exp_sat));
    end

    // Abort at cycle 8 after 3 matches; the next window starts from zero.
    run_window(16'h0049, 4'd2, 16'hFFFF, 8);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd2, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b1, 4'd2, 1'b1);
    check_value("abort_no_valid", int'(cnt_valid), 0);
    check_value("abort_alarm_idle", int'(alarm), 0);
    check_value("abort_no_ovr", int'(ovr), 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 4'd2, 1'b1);
    run_window(16'h0101, 4'd2, 16'hFFFF, WIN_LEN);
    check_value("restart_data", int'(cnt_data), 2);

    // Held result accepted on the same edge a window with 5 matches ends.
    run_window(16'h001F, 4'd0, 16'h8000, WIN_LEN);
    check_value("same_edge_valid", int'(cnt_valid), 1);
    check_value("same_edge_data", int'(cnt_data), 5);
    check_value("same_edge_ovr", int'(ovr), 0);

    // Consumer stalls across windows of 2 and 4 matches.
    run_window(16'h0003, 4'd0, 16'h0001, WIN_LEN);
    run_window(16'h000F, 4'd0, 16'h0000, WIN_LEN);
    check_value("stall_data", int'(cnt_data), 2);
    check_value("stall_ovr", int'(ovr), 1);
    check_value("stall_valid", int'(cnt_valid), 1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    check_value("stall_accepted", int'(cnt_valid), 0);

    // Reset at cycle 10 of a window while a result is held.
    run_window(16'h0007, 4'd0, 16'h0000, WIN_LEN - 1);
    run_window(16'h00FF, 4'd3, 16'h0000, 10);
    check_value("pre_reset_valid", int'(cnt_valid), 1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
    check_value("rst_cnt_valid", int'(cnt_valid), 0);
    check_value("rst_cnt_data", int'(cnt_data), 0);
    check_value("rst_sat", int'(sat), 0);
    check_value("rst_ovr", int'(ovr), 0);
    check_value("rst_alarm", int'(alarm), 0);

    // Randomized traffic against the model.
    dens = 4;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) dens = $urandom_range(1, 10);
      r_v  = ($urandom_range(0, 199) != 0);
      en_v = ($urandom_range(0, 29) != 0);
      m_v  = ($urandom_range(0, 9) < dens);
      t_v  = 4'($urandom_range(0, 15));
      rd_v = ($urandom_range(0, 2) != 0);
      apply_stimulus(r_v, en_v, m_v, t_v, rd_v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
